// File: rtl/mpt_plb.sv
// rtl/mpt_plb.sv - fully-associative permission lookaside buffer for MPT permissions
//
// Caches per-page {X,W,R} permissions tagged by {SDID, spa[XLEN-1:12]}.
// Lookups answer one cycle after acceptance. Walker fills install entries.
// Flushes invalidate entries selectively.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   mode_i                  current MPT mode (0 = BARE)
//   lookup_*                lookup request (valid/ready, sdid, spa, access type)
//   resp_*                  registered lookup response (valid, hit, allow, perms)
//   fill_*                  walker fill (valid, sdid, spa, perms)
//   flush_*                 flush strobe with optional SDID / page qualifiers
//   hit_cnt_o, miss_cnt_o   saturating lookup counters

module mpt_plb #(
  parameter int XLEN        = 64,
  parameter int SDID_LEN    = 6,
  parameter int NUM_ENTRIES = 8,
  parameter int MODE_LEN    = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MODE_LEN-1:0]  mode_i,
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic [SDID_LEN-1:0]  lookup_sdid_i,
  input  logic [XLEN-1:0]      lookup_spa_i,
  input  logic [1:0]           lookup_access_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic                 resp_allow_o,
  output logic [2:0]           resp_perms_o,
  input  logic                 fill_valid_i,
  input  logic [SDID_LEN-1:0]  fill_sdid_i,
  input  logic [XLEN-1:0]      fill_spa_i,
  input  logic [2:0]           fill_perms_i,
  input  logic                 flush_i,
  input  logic                 flush_sdid_en_i,
  input  logic [SDID_LEN-1:0]  flush_sdid_i,
  input  logic                 flush_addr_en_i,
  input  logic [XLEN-1:0]      flush_spa_i,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int PPN_W = XLEN - 12;
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
  logic [PPN_W-1:0]       ppn_q   [NUM_ENTRIES];
  logic [2:0]             perms_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       victim_q;
  logic [MODE_LEN-1:0]    mode_q;

  logic [PPN_W-1:0] lookup_ppn, fill_ppn, flush_ppn;
  assign lookup_ppn = lookup_spa_i[XLEN-1:12];
  assign fill_ppn   = fill_spa_i[XLEN-1:12];
  assign flush_ppn  = flush_spa_i[XLEN-1:12];

  // Page-offset bits never take part in tag matching.
  logic unused_offsets;
  assign unused_offsets = ^{lookup_spa_i[11:0], fill_spa_i[11:0], flush_spa_i[11:0]};

  logic lookup_acc, bare, mode_chg, fill_legal, fill_en, flush_all;
  assign lookup_ready_o = !flush_i;
  assign lookup_acc     = lookup_valid_i && !flush_i;
  assign bare           = (mode_q == '0);
  assign mode_chg       = (mode_i != mode_q);
  assign flush_all      = flush_i && !flush_sdid_en_i && !flush_addr_en_i;

  always_comb begin
    fill_legal = 1'b0;
    case (fill_perms_i)
      3'b001, 3'b011, 3'b100, 3'b101, 3'b111: fill_legal = 1'b1;
      default:                                fill_legal = 1'b0;
    endcase
  end

  // A mode change wipes the table at the same edge, so a coincident fill is dropped.
  assign fill_en = fill_valid_i && fill_legal && !flush_i && !mode_chg;

  // Lookup match: tags are unique, so OR-ing the matching perms selects one entry.
  logic       lk_hit;
  logic [2:0] lk_perms;
  always_comb begin
    lk_hit   = 1'b0;
    lk_perms = 3'b000;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && sdid_q[i] == lookup_sdid_i && ppn_q[i] == lookup_ppn) begin
        lk_hit   = 1'b1;
        lk_perms = lk_perms | perms_q[i];
      end
    end
  end

  // Fill placement: existing tag, else lowest free slot, else victim pointer.
  logic             fl_match, fl_free;
  logic [IDX_W-1:0] fl_match_idx, fl_free_idx, fill_idx;
  always_comb begin
    fl_match     = 1'b0;
    fl_free      = 1'b0;
    fl_match_idx = '0;
    fl_free_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && sdid_q[i] == fill_sdid_i && ppn_q[i] == fill_ppn) begin
        fl_match     = 1'b1;
        fl_match_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        fl_free     = 1'b1;
        fl_free_idx = IDX_W'(i);
      end
    end
    fill_idx = fl_match ? fl_match_idx : (fl_free ? fl_free_idx : victim_q);
  end

  logic [NUM_ENTRIES-1:0] flush_hit;
  always_comb begin
    flush_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      flush_hit[i] = (!flush_sdid_en_i || sdid_q[i] == flush_sdid_i) &&
                     (!flush_addr_en_i || ppn_q[i] == flush_ppn);
    end
  end

  logic       nxt_hit, nxt_allow;
  logic [2:0] nxt_perms;
  always_comb begin
    nxt_hit   = bare ? 1'b1 : lk_hit;
    nxt_perms = bare ? 3'b111 : (lk_hit ? lk_perms : 3'b000);
    case (lookup_access_i)
      2'd1:    nxt_allow = nxt_perms[0];
      2'd2:    nxt_allow = nxt_perms[1];
      2'd3:    nxt_allow = nxt_perms[2];
      default: nxt_allow = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      victim_q     <= '0;
      mode_q       <= '0;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_allow_o <= 1'b0;
      resp_perms_o <= 3'b000;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      mode_q       <= mode_i;
      resp_valid_o <= lookup_acc;
      if (lookup_acc) begin
        resp_hit_o   <= nxt_hit;
        resp_allow_o <= nxt_allow;
        resp_perms_o <= nxt_perms;
      end

      // Flush blocks lookups, so clearing and counting never coincide.
      if (flush_all) begin
        hit_cnt_o  <= '0;
        miss_cnt_o <= '0;
      end else if (lookup_acc && !bare) begin
        if (lk_hit && hit_cnt_o != '1)
          hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
        if (!lk_hit && miss_cnt_o != '1)
          miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
      end

      if (mode_chg)
        valid_q <= '0;
      else if (flush_i)
        valid_q <= valid_q & ~flush_hit;
      else if (fill_en)
        valid_q[fill_idx] <= 1'b1;

      if (fill_en && !fl_match && !fl_free)
        victim_q <= victim_q + IDX_W'(1);
    end
  end

  // Tag/permission storage needs no reset: valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      sdid_q[fill_idx]  <= fill_sdid_i;
      ppn_q[fill_idx]   <= fill_ppn;
      perms_q[fill_idx] <= fill_perms_i;
    end
  end

endmodule

// File: doc/mpt_plb.md
Name: mpt_plb

Overview:
- Parametrised, fully-associative Permission Lookaside Buffer (PLB) caching per-page MPT permissions, tagged by SDID and supervisor physical page number.
- Sits between the requester (LSU/fetch) and the MPT walker. It answers permission lookups with one-cycle latency, accepts fills from the walker after a miss, and supports selective flushes.
- Generalises the single-entry PLB record: configurable depth, XLEN, SDID width, mode awareness, replacement policy and performance counters.

Parameters:
- XLEN, 64, physical address width (32 or 64).
- SDID_LEN, 6, supervisor domain identifier width.
- NUM_ENTRIES, 8, PLB depth (power of two, 2..64).
- MODE_LEN, 4, MPT mode field width (2 when XLEN=32).
- CNT_WIDTH, 16, width of the hit/miss counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mode_i  in  MODE_LEN  current MPT mode; 0 = BARE.
- lookup_valid_i  in  1  lookup request.
- lookup_ready_o  out  1  lookup accepted.
- lookup_sdid_i  in  SDID_LEN  requesting domain.
- lookup_spa_i  in  XLEN  supervisor physical address.
- lookup_access_i  in  2  0 NONE, 1 READ, 2 WRITE, 3 EXEC.
- resp_valid_o  out  1  response valid, one cycle after accept.
- resp_hit_o  out  1  entry found (forced 1 in BARE).
- resp_allow_o  out  1  access permitted.
- resp_perms_o  out  3  cached permissions {X,W,R}.
- fill_valid_i  in  1  walker fill.
- fill_sdid_i  in  SDID_LEN  fill domain.
- fill_spa_i  in  XLEN  fill address.
- fill_perms_i  in  3  fill permissions {X,W,R}.
- flush_i  in  1  flush strobe.
- flush_sdid_en_i  in  1  qualify flush by SDID.
- flush_sdid_i  in  SDID_LEN  SDID to flush.
- flush_addr_en_i  in  1  qualify flush by page.
- flush_spa_i  in  XLEN  address to flush.
- hit_cnt_o  out  CNT_WIDTH  saturating hit count.
- miss_cnt_o  out  CNT_WIDTH  saturating miss count.

Behaviour:
- Reset: all entries invalid, victim pointer 0, resp_valid_o=0, resp_hit_o=0, resp_allow_o=0, resp_perms_o=0, counters 0, registered mode=0.
- Tag = {SDID, spa[XLEN-1:12]}. Matching is exact; at most one valid entry matches any tag.
- lookup_ready_o = !flush_i. A lookup is accepted on lookup_valid_i && lookup_ready_o.
- Acceptance in cycle N gives resp_valid_o=1 in cycle N+1 only, with no backpressure. The lookup sees table state before any same-cycle fill.
- Allow rules:
  - READ needs R. WRITE needs W. EXEC needs X. NONE gives allow=0.
  - On a miss: allow=0 and perms=0.
- BARE mode (registered mode == 0): the response is hit=1, perms=3'b111, allow=1 except for NONE. The table is not consulted and the counters are unchanged.
- Counters: each non-BARE accepted lookup increments the hit or miss counter. Both counters saturate at all-ones and are cleared by an unqualified flush.
- Fill legality: only legal encodings are written (3'b001, 011, 100, 101, 111). Illegal encodings are dropped silently.
- Fill placement:
  - If the tag matches a valid entry, update its perms in place.
  - Else use the lowest-index invalid entry.
  - Else replace the entry at the victim pointer, then advance the pointer modulo NUM_ENTRIES.
  - The pointer advances only on an eviction.
- Flush:
  - Both qualifiers clear: invalidate all entries.
  - sdid_en only: invalidate entries with a matching SDID.
  - addr_en only: invalidate entries with a matching page.
  - Both set: invalidate entries matching both.
  - Entries are invalidated at the next clock edge.
- Flush and fill in the same cycle: flush wins and the fill is dropped.
- Mode change: when mode_i differs from the registered mode, all entries are invalidated next cycle. The registered mode takes the new value at the same edge.
- Reset asserted mid-lookup: resp_valid_o is deasserted immediately and the pending response is lost.

Test Plan:
- Lookup SDID 5, spa 0x8000_1000 READ on an empty PLB, non-BARE mode -> resp_valid one cycle later, hit=0, allow=0, miss_cnt=1.
- Fill SDID 5, spa 0x8000_1000, perms 3'b001; then lookup READ -> hit=1, allow=1, perms=3'b001. Lookup WRITE -> hit=1, allow=0. hit_cnt=2.
- Fill NUM_ENTRIES+1 distinct pages -> the final fill evicts entry 0. A lookup of the first page misses; the second page still hits. Victim pointer = 1.
- Fill pages for SDID 1 and SDID 2; flush with sdid_en=1, flush_sdid=1 -> SDID 1 lookups miss, SDID 2 lookups hit. lookup_ready_o=0 during the flush cycle.
- Same-cycle flush (all) and fill -> the table is empty afterwards and both counters read 0.
- mode_i=0, lookup EXEC at any address -> hit=1, allow=1, perms=3'b111, counters unchanged. Switch mode to 1 -> previously filled entries miss.
